// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run monitor: state encoding and a
// constant-evaluable log2 helper used to size index and count ports.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   // Ceiling log2; returns 0 for values 0 and 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Read-before-write on a shared address; only the read register is reset
// so the array itself maps onto block or distributed RAM.
module trace_ram
   import cpu_dbg_pkg::*;
#(
   parameter  int unsigned WIDTH = 24,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store one trace entry per strobe.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port: one-cycle latency, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/cpu_trace_checker.sv
// Hardware run monitor for the 8-bit CPU: records retired {pc, instr}
// pairs into a circular buffer, counts RUN cycles and checks led_out
// against an expected value at timeout (or on first match).
module cpu_trace_checker
   import cpu_dbg_pkg::*;
#(
   parameter  int unsigned PC_W          = 8,
   parameter  int unsigned INSTR_W       = 16,
   parameter  int unsigned LED_W         = 4,
   parameter  int unsigned DEPTH         = 16,
   parameter  int unsigned TIMEOUT       = 50,
   parameter  bit          STOP_ON_MATCH = 1'b0,
   parameter  int unsigned CNT_W         = 16,
   localparam int unsigned IDX_W         = clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               trace_valid,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [LED_W-1:0]   led_in,
   input  logic [LED_W-1:0]   expected_led,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [PC_W-1:0]    rd_pc,
   output logic [INSTR_W-1:0] rd_instr,
   output logic [IDX_W:0]     entries,
   output logic               wrapped,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam int unsigned ENTRY_W = PC_W + INSTR_W;

   state_t               state;
   state_t               next_state;
   logic [IDX_W-1:0]     wr_ptr;
   logic [IDX_W-1:0]     rd_addr;
   logic                 wr_en;
   logic                 led_match;
   logic                 last_cycle;
   logic [ENTRY_W-1:0]   rd_data;

   assign led_match  = (led_in == expected_led);
   assign last_cycle = (cycle_count == CNT_W'(TIMEOUT - 1));
   assign wr_en      = (state == ST_RUN) && trace_valid;
   // Index 0 maps to the oldest entry; the modulo is free because DEPTH is a power of 2.
   assign rd_addr    = rd_idx + (wrapped ? wr_ptr : '0);

   // Next-state decode for the run FSM.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (STOP_ON_MATCH && led_match) begin
               next_state = ST_PASS;
            end else if (last_cycle) begin
               next_state = led_match ? ST_PASS : ST_FAIL;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State, status flags, cycle counter and trace pointer bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         cycle_count <= '0;
         entries     <= '0;
         wrapped     <= 1'b0;
         wr_ptr      <= '0;
      end else begin
         state <= next_state;
         busy  <= (next_state == ST_RUN);
         done  <= (next_state == ST_PASS) || (next_state == ST_FAIL);
         pass  <= (next_state == ST_PASS);
         if (state != ST_RUN) begin
            if (start) begin
               cycle_count <= '0;
               entries     <= '0;
               wrapped     <= 1'b0;
               wr_ptr      <= '0;
            end
         end else begin
            cycle_count <= cycle_count + 1'b1;
            if (trace_valid) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (entries == (IDX_W + 1)'(DEPTH)) begin
                  wrapped <= 1'b1;
               end else begin
                  entries <= entries + 1'b1;
               end
            end
         end
      end
   end

   trace_ram #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_trace_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data ({pc_in, instr_in}),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign rd_pc    = rd_data[ENTRY_W-1:INSTR_W];
   assign rd_instr = rd_data[INSTR_W-1:0];

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Self-checking bench for cpu_trace_checker: one timeout-mode and one
// stop-on-match instance share stimulus; a reference trace model feeds a
// scoreboard of expected read-port results.
module tb_cpu_trace_checker;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        trace_valid = 1'b0;
   logic [7:0]  pc_in = '0;
   logic [15:0] instr_in = '0;
   logic [3:0]  led_in = '0;
   logic [3:0]  expected_led = 4'b1111;
   logic [3:0]  rd_idx = '0;

   logic [7:0]  a_rd_pc, b_rd_pc;
   logic [15:0] a_rd_instr, b_rd_instr;
   logic [4:0]  a_entries, b_entries;
   logic        a_wrapped, b_wrapped, a_busy, b_busy, a_done, b_done, a_pass, b_pass;
   logic [15:0] a_cnt, b_cnt;

   int checks = 0;
   int errors = 0;

   logic [23:0] model[$];
   logic [23:0] exp_q[$];
   int          model_writes = 0;

   always #5 clk = ~clk;

   cpu_trace_checker #(
      .PC_W(8), .INSTR_W(16), .LED_W(4), .DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT), .STOP_ON_MATCH(1'b0), .CNT_W(16)
   ) dut_to (
      .clk(clk), .reset(reset), .start(start), .trace_valid(trace_valid),
      .pc_in(pc_in), .instr_in(instr_in), .led_in(led_in),
      .expected_led(expected_led), .rd_idx(rd_idx),
      .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .entries(a_entries),
      .wrapped(a_wrapped), .busy(a_busy), .done(a_done), .pass(a_pass),
      .cycle_count(a_cnt)
   );

   cpu_trace_checker #(
      .PC_W(8), .INSTR_W(16), .LED_W(4), .DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT), .STOP_ON_MATCH(1'b1), .CNT_W(16)
   ) dut_sm (
      .clk(clk), .reset(reset), .start(start), .trace_valid(trace_valid),
      .pc_in(pc_in), .instr_in(instr_in), .led_in(led_in),
      .expected_led(expected_led), .rd_idx(rd_idx),
      .rd_pc(b_rd_pc), .rd_instr(b_rd_instr), .entries(b_entries),
      .wrapped(b_wrapped), .busy(b_busy), .done(b_done), .pass(b_pass),
      .cycle_count(b_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      model.delete();
      model_writes = 0;
   endtask

   // One RUN cycle of stimulus; mirrors a capture into the reference trace.
   task automatic run_cycle(input logic tv, input logic [7:0] pc, input logic [3:0] led);
      trace_valid = tv;
      pc_in       = pc;
      instr_in    = {8'h5A, ~pc};
      led_in      = led;
      tick();
      if (tv) begin
         model.push_back({pc, 8'h5A, ~pc});
         model_writes++;
         if (model.size() > DEPTH) void'(model.pop_front());
      end
      trace_valid = 1'b0;
      led_in      = '0;
   endtask

   // Scoreboard readout of dut_to: expectation pushed when rd_idx is driven.
   task automatic check_reads(input int unsigned first, input int unsigned last);
      logic [23:0] e;
      for (int unsigned i = first; i <= last; i++) begin
         rd_idx = 4'(i);
         exp_q.push_back(model[i]);
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({a_rd_pc, a_rd_instr} !== e) begin
            errors++;
            $display("FAIL read_idx%0d: got pc=%h instr=%h want pc=%h instr=%h",
                     i, a_rd_pc, a_rd_instr, e[23:16], e[15:0]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if ({a_rd_pc, a_rd_instr, a_entries, a_wrapped, a_busy, a_done, a_pass, a_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got pc=%h instr=%h ent=%0d wr=%b busy=%b done=%b pass=%b cnt=%0d want all 0",
                  a_rd_pc, a_rd_instr, a_entries, a_wrapped, a_busy, a_done, a_pass, a_cnt);
      end
      reset = 1'b1;
      trace_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pc_in = 8'(i);
         tick();
         checks++;
         if ({a_entries, a_busy, a_done, a_pass, a_cnt, b_busy, b_done} !== '0) begin
            errors++;
            $display("FAIL idle_hold cyc%0d: got ent=%0d busy=%b done=%b pass=%b cnt=%0d want 0",
                     i, a_entries, a_busy, a_done, a_pass, a_cnt);
         end
      end
      trace_valid = 1'b0;
   endtask

   task automatic test_timeout_pass();
      do_start();
      checks++;
      if (a_busy !== 1'b1 || a_cnt !== 16'd0) begin
         errors++;
         $display("FAIL run_entry: got busy=%b cnt=%0d want busy=1 cnt=0", a_busy, a_cnt);
      end
      for (int c = 0; c < 50; c++) run_cycle(1'b1, 8'(c), (c == 49) ? 4'b1111 : 4'b0000);
      checks++;
      if (a_pass !== 1'b1 || a_done !== 1'b1 || a_busy !== 1'b0 || a_cnt !== 16'd50 ||
          a_entries !== 5'd16 || a_wrapped !== 1'b1) begin
         errors++;
         $display("FAIL timeout_pass: got pass=%b done=%b busy=%b cnt=%0d ent=%0d wr=%b want 1 1 0 50 16 1",
                  a_pass, a_done, a_busy, a_cnt, a_entries, a_wrapped);
      end
      checks++;
      if (b_pass !== 1'b1 || b_cnt !== 16'd50) begin
         errors++;
         $display("FAIL sm_late_match: got pass=%b cnt=%0d want 1 50", b_pass, b_cnt);
      end
      checks++;
      if (model[0][23:16] !== 8'h22 || model[15][23:16] !== 8'h31) begin
         errors++;
         $display("FAIL model_order: got %h %h want 22 31", model[0][23:16], model[15][23:16]);
      end
      check_reads(0, 15);
   endtask

   task automatic test_timeout_fail();
      do_start();
      for (int c = 0; c < 50; c++) run_cycle(1'b1, 8'(8'h40 + c), (c == 49) ? 4'b1110 : 4'b1111 & 4'(c % 15));
      checks++;
      if (a_done !== 1'b1 || a_pass !== 1'b0 || a_cnt !== 16'd50) begin
         errors++;
         $display("FAIL timeout_fail: got done=%b pass=%b cnt=%0d want 1 0 50", a_done, a_pass, a_cnt);
      end
      check_reads(0, 2);
   endtask

   task automatic test_early_match();
      do_start();
      for (int c = 1; c <= 7; c++) run_cycle(1'b0, 8'h00, (c == 7) ? 4'b1111 : 4'b0011);
      checks++;
      if (b_pass !== 1'b1 || b_done !== 1'b1 || b_busy !== 1'b0 || b_cnt !== 16'd7) begin
         errors++;
         $display("FAIL early_match: got pass=%b done=%b busy=%b cnt=%0d want 1 1 0 7",
                  b_pass, b_done, b_busy, b_cnt);
      end
      checks++;
      if (a_busy !== 1'b1 || a_cnt !== 16'd7) begin
         errors++;
         $display("FAIL timeout_ignores_match: got busy=%b cnt=%0d want 1 7", a_busy, a_cnt);
      end
      tick();
      checks++;
      if (b_cnt !== 16'd7 || b_pass !== 1'b1) begin
         errors++;
         $display("FAIL early_hold: got cnt=%0d pass=%b want 7 1", b_cnt, b_pass);
      end
      for (int c = 9; c <= 50; c++) run_cycle(1'b0, 8'h00, 4'b0000);
      checks++;
      if (a_done !== 1'b1 || a_pass !== 1'b0 || a_cnt !== 16'd50) begin
         errors++;
         $display("FAIL drain_fail: got done=%b pass=%b cnt=%0d want 1 0 50", a_done, a_pass, a_cnt);
      end
   endtask

   task automatic test_partial_restart();
      do_start();
      for (int c = 0; c < 50; c++)
         run_cycle(c < 5, (c < 5) ? 8'(8'hA0 + c) : 8'hEE, (c == 49) ? 4'b1111 : 4'b0000);
      checks++;
      if (a_entries !== 5'd5 || a_wrapped !== 1'b0 || a_pass !== 1'b1) begin
         errors++;
         $display("FAIL partial_fill: got ent=%0d wr=%b pass=%b want 5 0 1", a_entries, a_wrapped, a_pass);
      end
      check_reads(0, 4);
      do_start();
      checks++;
      if (a_entries !== 5'd0 || a_cnt !== 16'd0 || a_busy !== 1'b1 || a_done !== 1'b0 || a_wrapped !== 1'b0) begin
         errors++;
         $display("FAIL restart: got ent=%0d cnt=%0d busy=%b done=%b wr=%b want 0 0 1 0 0",
                  a_entries, a_cnt, a_busy, a_done, a_wrapped);
      end
   endtask

   task automatic test_reset_mid_run();
      for (int c = 1; c <= 20; c++) begin
         start = (c == 10);
         run_cycle(1'b1, 8'(c), 4'b0000);
      end
      start = 1'b0;
      checks++;
      if (a_cnt !== 16'd20 || a_busy !== 1'b1 || a_entries !== 5'd16 || a_wrapped !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored: got cnt=%0d busy=%b ent=%0d wr=%b want 20 1 16 1",
                  a_cnt, a_busy, a_entries, a_wrapped);
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({a_rd_pc, a_rd_instr, a_entries, a_wrapped, a_busy, a_done, a_pass, a_cnt} !== '0 ||
          {b_busy, b_done, b_pass, b_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid_run: got pc=%h ent=%0d wr=%b busy=%b done=%b pass=%b cnt=%0d want all 0",
                  a_rd_pc, a_entries, a_wrapped, a_busy, a_done, a_pass, a_cnt);
      end
      reset = 1'b1;
      repeat (5) tick();
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_cnt !== 16'd0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy=%b done=%b cnt=%0d want 0 0 0", a_busy, a_done, a_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_timeout_pass();
      test_timeout_fail();
      test_early_match();
      test_partial_restart();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Synthesizable, parametrised run monitor for the 8-bit CPU top. It moves the simulation pass/fail check into hardware so the same check runs on the board.
- Captures retired {PC, instruction} pairs into a circular trace buffer.
- Counts cycles after start and compares the LED output against an expected value, either at timeout or on the first match.
- Sits beside the datapath and taps pc, instruction and led_out. The result and the trace buffer are readable through a simple indexed read port.

Parameters:
- PC_W, 8, width of the captured program counter.
- INSTR_W, 16, width of the captured instruction.
- LED_W, 4, width of the LED compare vector.
- DEPTH, 16, trace entries; power of 2, at least 2.
- TIMEOUT, 50, cycles in RUN before the final check; at least 1.
- STOP_ON_MATCH, 0, when 1 the run ends PASS on the first cycle led_in equals expected_led.
- CNT_W, 16, width of cycle_count; must hold TIMEOUT.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-low.
- start, input, 1, pulse; begins a run from IDLE, PASS or FAIL.
- trace_valid, input, 1, CPU retire strobe; capture this cycle.
- pc_in, input, PC_W, CPU program counter.
- instr_in, input, INSTR_W, CPU instruction.
- led_in, input, LED_W, CPU led_out.
- expected_led, input, LED_W, compare value; sampled every cycle.
- rd_idx, input, log2(DEPTH), trace read index; 0 is the oldest valid entry.
- rd_pc, output, PC_W, registered read data.
- rd_instr, output, INSTR_W, registered read data.
- entries, output, log2(DEPTH)+1, number of valid entries; saturates at DEPTH.
- wrapped, output, 1, at least one entry was overwritten.
- busy, output, 1, high in RUN.
- done, output, 1, high in PASS or FAIL.
- pass, output, 1, high only in PASS.
- cycle_count, output, CNT_W, cycles spent in RUN during the current or last run.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs return 0: rd_pc, rd_instr, entries, wrapped, busy, done, pass, cycle_count.
  - Internal write pointer returns 0.
  - Reset mid-run aborts the run; no PASS/FAIL is reported.
- States: IDLE, RUN, PASS, FAIL, encoded 2 bits.
  - IDLE -> RUN on start.
  - PASS/FAIL -> RUN on start (restart).
  - start in RUN is ignored.
- On entering RUN (the edge where start is seen):
  - cycle_count, entries, wrapped and the write pointer clear to 0.
  - That start cycle does not capture and does not count.
- Each cycle in RUN:
  - cycle_count increments by 1.
  - If trace_valid, {pc_in, instr_in} is written at the write pointer, which then increments modulo DEPTH.
  - entries increments until it reaches DEPTH. A write when entries==DEPTH sets wrapped and overwrites the oldest entry.
- End of run:
  - When STOP_ON_MATCH==1 and led_in==expected_led: go to PASS on that edge.
  - Otherwise, at the cycle where cycle_count==TIMEOUT-1 (the TIMEOUT-th RUN cycle): go to PASS if led_in==expected_led, else FAIL.
  - A trace_valid on the final RUN cycle is still captured and counted.
- PASS/FAIL:
  - done=1, busy=0, pass=(state==PASS).
  - cycle_count, entries, wrapped and buffer contents hold until the next start or reset.
- Readout:
  - Physical address is (rd_idx + oldest) mod DEPTH.
  - oldest = 0 if !wrapped, else the write pointer.
  - rd_pc/rd_instr update one clk after rd_idx; latency 1, valid in every state.
  - rd_idx >= entries returns stale or undefined buffer data; no error.
  - Reads during RUN return the buffer as it stood before the same-edge write; no write-through.
- Outputs busy, done and pass are registered, decoded from the state register.

Decomposition:
- Package cpu_dbg_pkg holds:
  - the state encoding constants ST_IDLE, ST_RUN, ST_PASS, ST_FAIL;
  - a clog2 function used for index and entries widths.
- Sub-module trace_ram:
  - simple dual-port RAM, one write port and one registered read port, width PC_W+INSTR_W, depth DEPTH;
  - inferable as block or distributed RAM.
- FSM, counters and pointer logic stay in cpu_trace_checker.

Test Plan:
- Reset / idle:
  - Stimulus: reset low 3 cycles, then high with no start.
  - Required: all outputs 0; state stays IDLE for 20 cycles even with trace_valid=1.
- Timeout pass (STOP_ON_MATCH=0, TIMEOUT=50):
  - Stimulus: start; trace_valid=1 with pc_in=0x00..0x31; led_in=4'b1111 at cycle 50.
  - Required: pass=1, done=1, cycle_count=50, entries=16, wrapped=1.
  - Required: rd_idx=0 gives rd_pc=0x22; rd_idx=15 gives 0x31.
- Timeout fail:
  - Stimulus: same run with led_in=4'b1110 on the final cycle.
  - Required: done=1, pass=0, cycle_count=50.
- Early match (STOP_ON_MATCH=1):
  - Stimulus: led_in becomes 4'b1111 on the 7th RUN cycle.
  - Required: PASS, cycle_count=7, busy=0 on the next cycle.
- Partial fill and restart:
  - Stimulus: 5 trace_valid pulses (pc 0xA0..0xA4), then timeout.
  - Required: entries=5, wrapped=0, rd_idx=0 gives 0xA0.
  - Stimulus: start again.
  - Required: entries=0, cycle_count=0, busy=1.
- Reset mid-run:
  - Stimulus: reset low at cycle 20 of RUN.
  - Required: IDLE and all outputs 0; a start ignored during RUN leaves cycle_count uninterrupted.
